// File: rtl/raster_stamp_batcher.sv
// raster_stamp_batcher
//
// Purpose:
//   Serves a warp's raster-fetch request by pulling one stamp per active
//   thread from the raster unit's stamp stream. Stamps are packed into
//   NUM_LANES-wide batches, one batch per thread group (pid), and each batch
//   goes to the per-warp raster CSR store as a single write pulse. After the
//   last write, a per-thread "stamp received" mask is returned to the
//   requesting execute unit.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   req_valid/req_ready   fetch request handshake (accepted only when idle)
//   req_wid/req_uuid      warp id / instruction uuid of the request
//   req_tmask             active threads of the request
//   stamp_valid/ready     stamp stream handshake (ready is combinational)
//   stamp_data            stamp payload (flattened raster_stamp_t)
//   stamp_empty           raster unit exhausted (sticky until next frame)
//   write_enable          CSR store write pulse, one cycle per active pid
//   write_uuid/wid/pid    identification of the written batch
//   write_tmask           lanes of the batch that received a stamp
//   write_data            NUM_LANES stamps, lane 0 in the low bits
//   rsp_valid/rsp_ready   response handshake
//   rsp_wid/rsp_uuid      echo of the request
//   rsp_data              bit t set = thread t received a stamp
module raster_stamp_batcher #(
  parameter int CORE_ID     = 0,
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 1,
  parameter int NW_WIDTH    = 2,
  parameter int UUID_WIDTH  = 8,
  parameter int STAMP_WIDTH = 32,
  parameter int NUM_PIDS    = NUM_THREADS / NUM_LANES,
  parameter int PID_WIDTH   = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1,
  parameter int LANE_WIDTH  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [NW_WIDTH-1:0]              req_wid,
  input  logic [NUM_THREADS-1:0]           req_tmask,
  input  logic [UUID_WIDTH-1:0]            req_uuid,
  input  logic                             stamp_valid,
  output logic                             stamp_ready,
  input  logic [STAMP_WIDTH-1:0]           stamp_data,
  input  logic                             stamp_empty,
  output logic                             write_enable,
  output logic [UUID_WIDTH-1:0]            write_uuid,
  output logic [NW_WIDTH-1:0]              write_wid,
  output logic [PID_WIDTH-1:0]             write_pid,
  output logic [NUM_LANES-1:0]             write_tmask,
  output logic [NUM_LANES*STAMP_WIDTH-1:0] write_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [NW_WIDTH-1:0]              rsp_wid,
  output logic [UUID_WIDTH-1:0]            rsp_uuid,
  output logic [NUM_THREADS-1:0]           rsp_data
);

  // Batches must tile the thread range exactly; the core index only tags
  // trace output and must be a valid (non-negative) index.
  if ((NUM_THREADS % NUM_LANES) != 0 || CORE_ID < 0) begin : g_bad_cfg
    $error("raster_stamp_batcher: NUM_LANES must divide NUM_THREADS");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RSP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [NW_WIDTH-1:0]     r_wid;
  logic [UUID_WIDTH-1:0]   r_uuid;
  logic [NUM_THREADS-1:0]  r_tmask;
  logic [NUM_THREADS-1:0]  r_got;
  logic [PID_WIDTH-1:0]    r_pid;
  logic [LANE_WIDTH-1:0]   r_lane;
  logic [STAMP_WIDTH-1:0]  r_buf [NUM_LANES];

  // Per-pid views of the request mask, the latched mask and the got mask.
  logic [NUM_LANES-1:0]    w_req_pid_mask [NUM_PIDS];
  logic [NUM_LANES-1:0]    w_pid_mask     [NUM_PIDS];
  logic [NUM_LANES-1:0]    w_got_pid      [NUM_PIDS];
  logic [NUM_PIDS-1:0]     w_req_pid_any;
  logic [NUM_PIDS-1:0]     w_pid_any;
  logic [NUM_THREADS-1:0]  w_cursor_onehot;

  logic [PID_WIDTH-1:0]    w_first_pid;
  logic [LANE_WIDTH-1:0]   w_first_lane_req;
  logic [PID_WIDTH-1:0]    w_next_pid;
  logic                    w_next_pid_found;
  logic [LANE_WIDTH-1:0]   w_first_lane_next;
  logic [NUM_LANES-1:0]    w_cur_mask;
  logic [LANE_WIDTH-1:0]   w_next_lane;
  logic                    w_next_lane_found;

  logic                    w_req_fire;
  logic                    w_capture;
  logic                    w_advance;
  logic                    w_clear_buf;

  // Lowest set lane of a batch mask (0 when the mask is empty).
  function automatic logic [LANE_WIDTH-1:0] f_lowest_lane(input logic [NUM_LANES-1:0] mask);
    logic [LANE_WIDTH-1:0] res;
    res = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (mask[l]) res = LANE_WIDTH'(l);
    end
    return res;
  endfunction

  genvar gi;

  generate
    for (gi = 0; gi < NUM_PIDS; gi++) begin : g_pid
      assign w_req_pid_mask[gi] = req_tmask[gi*NUM_LANES +: NUM_LANES];
      assign w_pid_mask[gi]     = r_tmask[gi*NUM_LANES +: NUM_LANES];
      assign w_got_pid[gi]      = r_got[gi*NUM_LANES +: NUM_LANES];
      assign w_req_pid_any[gi]  = |req_tmask[gi*NUM_LANES +: NUM_LANES];
      assign w_pid_any[gi]      = |r_tmask[gi*NUM_LANES +: NUM_LANES];
    end

    // Thread bit addressed by the (pid, lane) cursor.
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      assign w_cursor_onehot[gi] = (r_pid == PID_WIDTH'(gi / NUM_LANES)) &&
                                   (r_lane == LANE_WIDTH'(gi % NUM_LANES));
    end
  endgenerate

  // Priority encoders: these let inactive lanes and inactive pids be skipped
  // without spending a cycle on them.
  always_comb begin
    w_first_pid = '0;
    for (int p = NUM_PIDS - 1; p >= 0; p--) begin
      if (w_req_pid_any[p]) w_first_pid = PID_WIDTH'(p);
    end

    w_next_pid       = '0;
    w_next_pid_found = 1'b0;
    for (int p = NUM_PIDS - 1; p >= 0; p--) begin
      if (w_pid_any[p] && (p > int'(r_pid))) begin
        w_next_pid       = PID_WIDTH'(p);
        w_next_pid_found = 1'b1;
      end
    end

    w_cur_mask        = w_pid_mask[r_pid];
    w_next_lane       = '0;
    w_next_lane_found = 1'b0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (w_cur_mask[l] && (l > int'(r_lane))) begin
        w_next_lane       = LANE_WIDTH'(l);
        w_next_lane_found = 1'b1;
      end
    end

    w_first_lane_req  = f_lowest_lane(w_req_pid_mask[w_first_pid]);
    w_first_lane_next = f_lowest_lane(w_pid_mask[w_next_pid]);
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    stamp_ready  = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = 1'b0;
    w_req_fire   = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_req_fire   = 1'b1;
          w_state_next = (|req_tmask) ? ST_FILL : ST_RSP;
        end
      end
      ST_FILL: begin
        // A valid stamp wins over empty; with neither, the cursor stalls.
        if (stamp_valid) begin
          stamp_ready = 1'b1;
          w_capture   = 1'b1;
          w_advance   = 1'b1;
        end else if (stamp_empty) begin
          w_advance   = 1'b1;
        end
        if (w_advance && !w_next_lane_found) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        write_enable = 1'b1;
        w_state_next = w_next_pid_found ? ST_FILL : ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_clear_buf = w_req_fire || (r_state == ST_WRITE);

  // Request context, cursor and received mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wid   <= '0;
      r_uuid  <= '0;
      r_tmask <= '0;
      r_got   <= '0;
      r_pid   <= '0;
      r_lane  <= '0;
    end else begin
      if (w_req_fire) begin
        r_wid   <= req_wid;
        r_uuid  <= req_uuid;
        r_tmask <= req_tmask;
        r_got   <= '0;
        r_pid   <= w_first_pid;
        r_lane  <= w_first_lane_req;
      end
      if (w_capture) r_got <= r_got | w_cursor_onehot;
      if (w_advance && w_next_lane_found) r_lane <= w_next_lane;
      if ((r_state == ST_WRITE) && w_next_pid_found) begin
        r_pid  <= w_next_pid;
        r_lane <= w_first_lane_next;
      end
    end
  end

  // Lane buffer: lanes that never receive a stamp stay zero in the write.
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          r_buf[gi] <= '0;
        else if (w_clear_buf)
          r_buf[gi] <= '0;
        else if (w_capture && (r_lane == LANE_WIDTH'(gi)))
          r_buf[gi] <= stamp_data;
      end
      assign write_data[gi*STAMP_WIDTH +: STAMP_WIDTH] = r_buf[gi];
    end
  endgenerate

  assign write_uuid  = r_uuid;
  assign write_wid   = r_wid;
  assign write_pid   = r_pid;
  assign write_tmask = w_got_pid[r_pid];
  assign rsp_wid     = r_wid;
  assign rsp_uuid    = r_uuid;
  assign rsp_data    = r_got;

endmodule

// File: tb/tb_raster_stamp_batcher.sv
module tb_raster_stamp_batcher;
  localparam int NT  = 4;
  localparam int NL  = 2;
  localparam int NWW = 2;
  localparam int UW  = 8;
  localparam int SW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [NWW-1:0]    req_wid;
  logic [NT-1:0]     req_tmask;
  logic [UW-1:0]     req_uuid;
  logic              stamp_valid;
  logic              stamp_ready;
  logic [SW-1:0]     stamp_data;
  logic              stamp_empty;
  logic              write_enable;
  logic [UW-1:0]     write_uuid;
  logic [NWW-1:0]    write_wid;
  logic [0:0]        write_pid;
  logic [NL-1:0]     write_tmask;
  logic [NL*SW-1:0]  write_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NWW-1:0]    rsp_wid;
  logic [UW-1:0]     rsp_uuid;
  logic [NT-1:0]     rsp_data;

  raster_stamp_batcher #(
    .CORE_ID(0), .NUM_THREADS(NT), .NUM_LANES(NL), .NW_WIDTH(NWW),
    .UUID_WIDTH(UW), .STAMP_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
    .req_tmask(req_tmask), .req_uuid(req_uuid),
    .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
    .stamp_data(stamp_data), .stamp_empty(stamp_empty),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
    .write_pid(write_pid), .write_tmask(write_tmask), .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid),
    .rsp_uuid(rsp_uuid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0] tmask;
    int            avail;        // stamps the source will supply
    bit            use_empty;    // raise stamp_empty once supply runs out
    int            stall_at;     // first stalled cycle (stall_len 0 = none)
    int            stall_len;
    int            rsp_hold;     // cycles rsp_ready is held low
    int            exp_first_wr; // -1 = no write expected
    int            exp_rsp_cyc;
    logic [NT-1:0] exp_rsp;
    int            exp_consumed;
    int            exp_writes;
  } vec_t;

  typedef struct {
    logic          pid;
    logic [NL-1:0] tm;
    logic [NL*SW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [SW-1:0] stamp_of(input int i);
    return 16'hA100 + 16'(i * 16'h0111);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_case(input vec_t v, input int idx);
    wr_t  e;
    int   sidx, consumed, nwr, first_wr, rsp_cyc, held;
    bit   done, stalled;
    // Reference: walk pids in order, lanes low to high, handing out stamps
    // while the supply lasts.
    sidx = 0;
    for (int p = 0; p < NT / NL; p++) begin
      if (v.tmask[p*NL +: NL] != '0) begin
        e.pid = p[0]; e.tm = '0; e.data = '0;
        for (int l = 0; l < NL; l++) begin
          if (v.tmask[p*NL + l] && sidx < v.avail) begin
            e.tm[l] = 1'b1;
            e.data[l*SW +: SW] = stamp_of(sidx);
            sidx++;
          end
        end
        exp_q.push_back(e);
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_tmask = v.tmask;
    req_wid = NWW'(idx); req_uuid = UW'(8'h30 + idx);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_tmask = '0;

    consumed = 0; nwr = 0; first_wr = -1; rsp_cyc = -1; held = 0; done = 1'b0;
    for (int n = 1; n <= 80 && !done; n++) begin
      stalled     = (v.stall_len > 0) && (n >= v.stall_at) && (n < v.stall_at + v.stall_len);
      stamp_valid = !stalled && (consumed < v.avail);
      stamp_empty = !stalled && v.use_empty && (consumed >= v.avail);
      stamp_data  = stamp_valid ? stamp_of(consumed) : 16'hDEAD;
      #1;
      if (n == 1) chk("req_ready_busy", 64'(req_ready), 64'd0);
      if (stalled) chk("stall_quiet", 64'({write_enable, stamp_ready, rsp_valid}), 64'd0);
      if (write_enable) begin
        nwr++;
        if (first_wr < 0) first_wr = n;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: cycle %0d pid %0d", n, write_pid);
        end else begin
          e = exp_q.pop_front();
          chk("write_pid", 64'(write_pid), 64'(e.pid));
          chk("write_tmask", 64'(write_tmask), 64'(e.tm));
          chk("write_data", 64'(write_data), 64'(e.data));
          chk("write_wid", 64'(write_wid), 64'(idx[NWW-1:0]));
        end
      end
      if (stamp_valid && stamp_ready) consumed++;
      if (rsp_valid) begin
        if (rsp_cyc < 0) begin
          rsp_cyc = n;
          chk("rsp_cycle", 64'(rsp_cyc), 64'(v.exp_rsp_cyc));
          chk("rsp_wid", 64'(rsp_wid), 64'(idx[NWW-1:0]));
          chk("rsp_uuid", 64'(rsp_uuid), 64'(8'h30 + idx));
        end
        chk("rsp_data", 64'(rsp_data), 64'(v.exp_rsp));
        if (held < v.rsp_hold) begin
          held++; rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1; done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0; stamp_valid = 1'b0; stamp_empty = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: case %0d no response", idx);
    end
    #1;
    chk("back_to_idle", 64'({req_ready, rsp_valid}), 64'b10);
    chk("first_write_cycle", 64'(first_wr), 64'(v.exp_first_wr));
    chk("write_count", 64'(nwr), 64'(v.exp_writes));
    chk("stamps_consumed", 64'(consumed), 64'(v.exp_consumed));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    $display("case %0d tmask=%b writes=%0d consumed=%0d rsp_cycle=%0d", idx, v.tmask, nwr, consumed, rsp_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            tmask  avail empty stall  len hold fw rsp  exp     cons wr
    vecs[0] = '{4'b1111, 4, 1'b0, 0, 0, 0,  3,  7, 4'b1111, 4, 2};
    vecs[1] = '{4'b1010, 4, 1'b0, 0, 0, 0,  2,  5, 4'b1010, 2, 2};
    vecs[2] = '{4'b1100, 4, 1'b0, 0, 0, 0,  3,  4, 4'b1100, 2, 1};
    vecs[3] = '{4'b1111, 1, 1'b1, 0, 0, 0,  3,  7, 4'b0001, 1, 2};
    vecs[4] = '{4'b1111, 4, 1'b0, 2, 5, 0,  8, 12, 4'b1111, 4, 2};
    vecs[5] = '{4'b0110, 4, 1'b0, 0, 0, 3,  2,  5, 4'b0110, 2, 2};
    vecs[6] = '{4'b0000, 4, 1'b0, 0, 0, 0, -1,  1, 4'b0000, 0, 0};

    reset = 1'b1; req_valid = 1'b0; req_wid = '0; req_tmask = '0; req_uuid = '0;
    stamp_valid = 1'b1; stamp_data = 16'h1234; stamp_empty = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({req_ready, stamp_ready, write_enable, rsp_valid}), 64'b1000);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    reset = 1'b0; stamp_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", 64'({req_ready, stamp_ready, write_enable, rsp_valid}), 64'b1000);

    for (int i = 0; i < 7; i++) run_case(vecs[i], i);

    // Reset asserted while the pid0 write is on the outputs.
    @(negedge clk);
    req_valid = 1'b1; req_tmask = 4'b1111; req_wid = 2'd3; req_uuid = 8'hEE;
    @(posedge clk); #1;
    req_valid = 1'b0; req_tmask = '0;
    for (int n = 0; n < 2; n++) begin
      stamp_valid = 1'b1; stamp_data = stamp_of(n);
      @(posedge clk); #1;
    end
    stamp_valid = 1'b0;
    #1;
    chk("rst_pre_write", 64'({write_enable, write_tmask}), 64'b111);
    stamp_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_async_outputs", 64'({req_ready, stamp_ready, write_enable, rsp_valid}), 64'b1000);
    chk("rst_async_write", 64'({write_pid, write_tmask, write_data}), 64'd0);
    chk("rst_async_rsp", 64'({rsp_data, rsp_wid, rsp_uuid}), 64'd0);
    $display("reset during write: outputs cleared");
    @(negedge clk);
    reset = 1'b0; stamp_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("rst_dropped", 64'({req_ready, write_enable, rsp_valid}), 64'b100);
    end
    run_case(vecs[0], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/raster_stamp_batcher.md
# raster_stamp_batcher

Upstream feeder of the per-warp raster CSR store. Executes a warp's raster-fetch request by pulling one `raster_stamp_t` per active thread from the raster unit's stamp stream. Packs the stamps into `NUM_LANES`-wide batches, one batch per thread group (`pid`), and issues each batch as a single write pulse to the CSR store. After the last write it returns a per-thread "stamp received" mask to the requesting execute unit.

## Interface
- `CORE_ID`, 0, core index; used in trace output only.
- `NUM_LANES`, 1, lanes per write batch; must divide `` `NUM_THREADS ``.
- `PID_WIDTH`, `` `LOG2UP(`NUM_THREADS / NUM_LANES) ``, thread-group index width. `NUM_PIDS = `NUM_THREADS / NUM_LANES`.

Ports:
- `clk` in 1 — the single clock.
- `reset` in 1 — asynchronous, active-high.
- `req_valid` in 1 — fetch request.
- `req_ready` out 1 — request accepted when both are high.
- `req_wid` in `` `NW_WIDTH `` — warp id.
- `req_tmask` in `` `NUM_THREADS `` — active threads.
- `req_uuid` in `` `UUID_WIDTH `` — instruction uuid.
- `stamp_valid` in 1 — stamp available.
- `stamp_ready` out 1 — stamp consumed when both are high.
- `stamp_data` in `raster_stamp_t` — stamp payload.
- `stamp_empty` in 1 — raster unit exhausted; sticky until next frame.
- `write_enable` out 1 — CSR write pulse.
- `write_uuid`, `write_wid`, `write_pid`, `write_tmask` (`NUM_LANES`), `write_data` (`raster_stamp_t [NUM_LANES]`) — outputs to the CSR store.
- `rsp_valid` out 1 — response valid.
- `rsp_ready` in 1 — response handshake.
- `rsp_wid`, `rsp_uuid` out — echo of the request.
- `rsp_data` out `` `NUM_THREADS `` — bit *t* = thread *t* received a stamp.

## Operation
- **States:** IDLE, FILL, WRITE, RSP.
- **IDLE**
  - `req_ready`=1.
  - On handshake, latch wid, uuid and tmask; clear `got` mask and the lane buffer.
  - tmask==0 → RSP. Otherwise → FILL at the lowest pid with active lanes, cursor at that pid's lowest active lane.
- **FILL** (one cursor lane per cycle; inactive lanes are skipped via priority encoder, zero cycles)
  - `stamp_valid`=1: `stamp_ready`=1; capture `stamp_data` into `buf[lane]`; set `got[pid*NUM_LANES+lane]`.
  - `stamp_valid`=0 and `stamp_empty`=1: `stamp_ready`=0; lane left zero, `got` bit 0; cursor advances.
  - Both 0: stall; cursor and state hold.
  - `stamp_valid` has priority over `stamp_empty`.
  - After the pid's last active lane → WRITE.
- **WRITE** (exactly one cycle)
  - `write_enable`=1, `write_pid`=pid, `write_tmask`=`got` slice for the pid, `write_data`=buf.
  - Unfilled lanes carry zero data.
  - The write is issued even when `write_tmask`==0.
  - Next: clear buf; go to the next pid with active lanes (FILL), or RSP if none remain.
- **RSP**
  - `rsp_valid`=1, `rsp_data`=`got`.
  - Holds until `rsp_ready`, then → IDLE.
- The CSR store accepts writes unconditionally, so WRITE has no backpressure.
- Only one request is in flight at a time; `req_ready`=0 outside IDLE.

## Timing
- **Reset** (async, any state): state=IDLE; `req_ready`=1; `stamp_ready`=0; `write_enable`=0; `rsp_valid`=0; `got`, buf, latched wid/uuid/tmask/pid = 0.
  - A request mid-flight is dropped; no further write or response is issued for it.
- **Latency:** request handshake at cycle 0. With stamps always valid, *K* active threads in *P* active pids give:
  - FILL: cycles 1..K, interleaved with WRITE cycles.
  - First write at cycle k₀+1, where k₀ = active lanes in the first pid.
  - `rsp_valid` first high at cycle K+P+1.
- `stamp_ready` is combinational from state, cursor and `stamp_valid`/`stamp_empty`. All other outputs are registered-state decodes.
- `stamp_empty` rising mid-request: remaining active lanes each take one cycle and are marked not received.
- **rsp_data width rule:** only bits in the latched tmask can be 1.

## Test plan
- `NUM_THREADS`=4, `NUM_LANES`=2, tmask=4'b1111, stamps S0..S3 always valid:
  - cycle 3: write pid0 tmask=2'b11 data {S1,S0};
  - cycle 6: write pid1 tmask=2'b11 data {S3,S2};
  - cycle 7: rsp_data=4'b1111.
- tmask=4'b1010: pid0 write tmask=2'b10 with lane0 data 0, then pid1 write tmask=2'b10; exactly 2 stamps consumed; rsp_data=4'b1010.
- tmask=4'b1100: pid0 is skipped (no write); a single pid1 write occurs; rsp at cycle 4.
- tmask=4'b1111, one stamp supplied, then `stamp_empty`=1: pid0 tmask=2'b01, pid1 tmask=2'b00 (write still pulsed); rsp_data=4'b0001.
- **Stall:** hold `stamp_valid`=0, `stamp_empty`=0 for 5 cycles in FILL → no state or output change; resume gives the same result delayed by 5 cycles.
- **Reset:** assert reset during WRITE of pid0 → outputs go to reset values immediately; a new request afterwards completes normally. `rsp_ready`=0 for 3 cycles in RSP → `rsp_valid` and `rsp_data` held stable.
